// File: rtl/regs_pkg.sv
// Shared parameters and payload types for the register-file writeback path.
package regs_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 1 << REG_AW;

    // Requester indices; also the encoding of the arbiter priority bit
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t         addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/regs_scoreboard.sv
// Pending-destination scoreboard with combinational RAW/WAW hazard check.
module regs_scoreboard
    import regs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_valid,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_valid,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [REG_AW-1:0] chk_rs1_addr,
    input  logic [REG_AW-1:0] chk_rs2_addr,
    input  logic [REG_AW-1:0] chk_rd_addr,
    output logic [NREG-1:0]   busy,
    output logic              stall_c
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;

    // Next scoreboard: clear on writeback, then set on issue so a same-cycle set wins
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_valid) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Source operands also hit on the in-flight write the register file has not captured yet
    always_comb begin
        hit_rs1 = (chk_rs1_addr != '0) &
                  (busy_q[chk_rs1_addr] | (wb_we & (wb_addr == chk_rs1_addr)));
        hit_rs2 = (chk_rs2_addr != '0) &
                  (busy_q[chk_rs2_addr] | (wb_we & (wb_addr == chk_rs2_addr)));
        hit_rd  = (chk_rd_addr != '0) & busy_q[chk_rd_addr];
        stall_c = hit_rs1 | hit_rs2 | hit_rd;
    end

    assign busy = busy_q;

endmodule

// File: rtl/regs_wb_ctrl.sv
// Writeback controller: round-robin ALU/LSU arbiter, registered write port, scoreboard.
module regs_wb_ctrl
    import regs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_addr,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_addr,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              we,
    output logic [REG_AW-1:0] wr_addr,
    output logic [XLEN-1:0]   wr_data,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_addr,
    input  logic [REG_AW-1:0] chk_rs1_addr,
    input  logic [REG_AW-1:0] chk_rs2_addr,
    input  logic [REG_AW-1:0] chk_rd_addr,
    output logic              stall,
    output logic [NREG-1:0]   busy
);

    logic              prio_q;
    logic              prio_d;
    logic              we_q;
    logic              we_d;
    logic [REG_AW-1:0] wr_addr_q;
    logic [REG_AW-1:0] wr_addr_d;
    logic [XLEN-1:0]   wr_data_q;
    logic [XLEN-1:0]   wr_data_d;
    logic              xfer;
    wb_req_t           win;

    // Round-robin grant; readies are held low while in reset
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (rst_n) begin
            if (prio_q == 1'(REQ_ALU)) begin
                alu_ready = alu_valid;
                lsu_ready = lsu_valid & ~alu_valid;
            end else begin
                lsu_ready = lsu_valid;
                alu_ready = alu_valid & ~lsu_valid;
            end
        end
    end

    // Winning payload, next priority and next write-port state
    always_comb begin
        xfer      = alu_ready | lsu_ready;
        win       = lsu_ready ? wb_req_t'{addr: lsu_addr, data: lsu_data}
                              : wb_req_t'{addr: alu_addr, data: alu_data};
        prio_d    = prio_q;
        we_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (alu_ready) begin
            prio_d = 1'(REQ_LSU);
        end else if (lsu_ready) begin
            prio_d = 1'(REQ_ALU);
        end
        if (xfer) begin
            we_d      = (win.addr != '0);
            wr_addr_d = win.addr;
            wr_data_d = win.data;
        end
    end

    // Arbiter priority and write-port registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q    <= 1'(REQ_ALU);
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            prio_q    <= prio_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign we      = we_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    regs_scoreboard u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_valid    (iss_valid),
        .set_addr     (iss_addr),
        .clr_valid    (xfer),
        .clr_addr     (win.addr),
        .wb_we        (we_q),
        .wb_addr      (wr_addr_q),
        .chk_rs1_addr (chk_rs1_addr),
        .chk_rs2_addr (chk_rs2_addr),
        .chk_rd_addr  (chk_rd_addr),
        .busy         (busy),
        .stall_c      (stall)
    );

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Directed self-checking bench for regs_wb_ctrl.
module tb_regs_wb_ctrl;
    import regs_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_addr;
    logic [XLEN-1:0]   alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_addr;
    logic [XLEN-1:0]   lsu_data;
    logic              we;
    logic [REG_AW-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              iss_valid;
    logic [REG_AW-1:0] iss_addr;
    logic [REG_AW-1:0] chk_rs1_addr;
    logic [REG_AW-1:0] chk_rs2_addr;
    logic [REG_AW-1:0] chk_rd_addr;
    logic              stall;
    logic [NREG-1:0]   busy;

    int checks;
    int errors;

    regs_wb_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_addr     (lsu_addr),
        .lsu_data     (lsu_data),
        .we           (we),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .iss_valid    (iss_valid),
        .iss_addr     (iss_addr),
        .chk_rs1_addr (chk_rs1_addr),
        .chk_rs2_addr (chk_rs2_addr),
        .chk_rd_addr  (chk_rd_addr),
        .stall        (stall),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_addr = 5'd6; lsu_data = 32'h22;
        @(negedge clk); #1;
        checks++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_early got alu=%b lsu=%b exp 0 0", alu_ready, lsu_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got alu=%b lsu=%b exp 0 0", alu_ready, lsu_ready);
        end
        checks++;
        if (we !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'h0) begin
            errors++; $display("FAIL reset_port got we=%b addr=%0d data=%0h exp 0 0 0", we, wr_addr, wr_data);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++; $display("FAIL reset_busy got %h exp 00000000", busy);
        end
    endtask

    task automatic test_contention();
        logic             exp_alu;
        logic [REG_AW-1:0] exp_addr;
        logic [XLEN-1:0]   exp_data;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            #1;
            exp_alu = ((i % 2) == 0);
            checks++;
            if (alu_ready !== exp_alu || lsu_ready !== ~exp_alu) begin
                errors++; $display("FAIL contention_grant[%0d] got alu=%b lsu=%b exp alu=%b lsu=%b",
                                   i, alu_ready, lsu_ready, exp_alu, ~exp_alu);
            end
            if (i == 0) begin
                checks++;
                if (we !== 1'b0) begin
                    errors++; $display("FAIL contention_we0 got %b exp 0", we);
                end
            end else begin
                exp_addr = exp_alu ? 5'd6 : 5'd5;
                exp_data = exp_alu ? 32'h22 : 32'h11;
                checks++;
                if (we !== 1'b1 || wr_addr !== exp_addr || wr_data !== exp_data) begin
                    errors++; $display("FAIL contention_write[%0d] got we=%b addr=%0d data=%0h exp 1 %0d %0h",
                                       i, we, wr_addr, wr_data, exp_addr, exp_data);
                end
            end
        end
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        checks++;
        if (we !== 1'b1 || wr_addr !== 5'd6 || wr_data !== 32'h22) begin
            errors++; $display("FAIL contention_last got we=%b addr=%0d data=%0h exp 1 6 22", we, wr_addr, wr_data);
        end
        @(negedge clk); #1;
        checks++;
        if (we !== 1'b0 || wr_addr !== 5'd6 || wr_data !== 32'h22) begin
            errors++; $display("FAIL contention_idle got we=%b addr=%0d data=%0h exp 0 6 22", we, wr_addr, wr_data);
        end
    endtask

    task automatic test_x0_write();
        @(negedge clk);
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hDEAD;
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++; $display("FAIL x0_grant got alu=%b lsu=%b exp 0 1", alu_ready, lsu_ready);
        end
        @(negedge clk);
        lsu_valid = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0) begin
            errors++; $display("FAIL x0_we got %b exp 0", we);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++; $display("FAIL x0_busy got %h exp 00000000", busy);
        end
    endtask

    task automatic test_hazard();
        @(negedge clk);
        iss_valid = 1'b1; iss_addr = 5'd7; chk_rs1_addr = 5'd7;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL hazard_pre got %b exp 0", stall);
        end
        @(negedge clk);
        iss_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 32'h80 || stall !== 1'b1) begin
            errors++; $display("FAIL hazard_busy got busy=%h stall=%b exp 00000080 1", busy, stall);
        end
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || stall !== 1'b1) begin
            errors++; $display("FAIL hazard_xfer got ready=%b stall=%b exp 1 1", alu_ready, stall);
        end
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        checks++;
        if (we !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h77) begin
            errors++; $display("FAIL hazard_write got we=%b addr=%0d data=%0h exp 1 7 77", we, wr_addr, wr_data);
        end
        checks++;
        if (busy !== 32'h0 || stall !== 1'b1) begin
            errors++; $display("FAIL hazard_we_cycle got busy=%h stall=%b exp 00000000 1", busy, stall);
        end
        @(negedge clk); #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL hazard_clear got %b exp 0", stall);
        end
        chk_rs1_addr = 5'd0;
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        iss_valid = 1'b1; iss_addr = 5'd9;
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h99;
        #1;
        checks++;
        if (lsu_ready !== 1'b1) begin
            errors++; $display("FAIL setwins_grant got %b exp 1", lsu_ready);
        end
        @(negedge clk);
        iss_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 32'h200 || we !== 1'b1 || wr_addr !== 5'd9) begin
            errors++; $display("FAIL setwins_busy got busy=%h we=%b addr=%0d exp 00000200 1 9", busy, we, wr_addr);
        end
        // lsu still valid: second write to x9 retires the issue
        @(negedge clk);
        lsu_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 32'h0) begin
            errors++; $display("FAIL setwins_retire got %h exp 00000000", busy);
        end
    endtask

    task automatic test_waw();
        @(negedge clk);
        iss_valid = 1'b1; iss_addr = 5'd3;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++; $display("FAIL waw_grant got %b exp 1", alu_ready);
        end
        @(negedge clk);
        iss_valid = 1'b0; alu_valid = 1'b0;
        chk_rd_addr = 5'd3;
        #1;
        checks++;
        if (busy !== 32'h8 || we !== 1'b1 || wr_addr !== 5'd4) begin
            errors++; $display("FAIL waw_state got busy=%h we=%b addr=%0d exp 00000008 1 4", busy, we, wr_addr);
        end
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL waw_rd_stall got %b exp 1", stall);
        end
        chk_rd_addr = 5'd4;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL waw_rd_no_we_term got %b exp 0", stall);
        end
        chk_rd_addr = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL waw_rd_x0 got %b exp 0", stall);
        end
        chk_rs2_addr = 5'd3;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL waw_rs2_stall got %b exp 1", stall);
        end
        chk_rs2_addr = 5'd0;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rst_n = 1'b0;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        checks++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_ready got alu=%b lsu=%b exp 0 0", alu_ready, lsu_ready);
        end
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 32'h0 || we !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'h0) begin
            errors++; $display("FAIL midrst_state got busy=%h we=%b addr=%0d data=%0h exp 0 0 0 0",
                               busy, we, wr_addr, wr_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_addr = '0;
        chk_rs1_addr = '0; chk_rs2_addr = '0; chk_rd_addr = '0;
        test_reset();
        test_contention();
        test_x0_write();
        test_hazard();
        test_set_wins();
        test_waw();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regs_wb_ctrl.md
# regs_wb_ctrl

Writeback controller for the integer register file. It shares the file's single write port between two writeback requesters, the ALU and the LSU, using round-robin arbitration. It registers the winning write onto the port and keeps a 32-entry scoreboard of pending destinations. The issue stage uses the scoreboard's combinational stall to hold back RAW and WAW hazards.

## Interface
- XLEN, 32, data width
- REG_AW, 5, register address width
- NREG, 32, register count (2**REG_AW)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request granted this cycle
- alu_addr  in  REG_AW  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid / lsu_ready / lsu_addr / lsu_data  same as ALU, for the LSU
- we  out  1  register-file write enable
- wr_addr  out  REG_AW  register-file write address
- wr_data  out  XLEN  register-file write data
- iss_valid  in  1  an instruction with a destination issues this cycle
- iss_addr  in  REG_AW  destination register of the issuing instruction
- chk_rs1_addr, chk_rs2_addr, chk_rd_addr  in  REG_AW  operands of the instruction waiting to issue
- stall  out  1  hazard on the checked operands
- busy  out  NREG  scoreboard bits (debug and verification)

## Operation
- **Arbiter:**
  - Holds a one-bit `prio`: 0 favours ALU, 1 favours LSU.
  - Grant goes to the favoured requester if it is valid, otherwise to the other requester if it is valid.
  - `x_ready` equals the grant. It is combinational and may depend on both valids.
  - At most one grant per cycle. A transfer occurs when `valid && ready`.
  - On any grant, `prio` becomes the index of the non-winner.
  - A loser keeps valid and its payload stable until it is granted.
- **Write stage:** on a transfer, next cycle `we = (addr != 0)`, `wr_addr = addr`, `wr_data = data`. With no transfer, next cycle `we = 0`; `wr_addr` and `wr_data` hold their values.
- **x0 handling:** a write to x0 is accepted and consumed, but `we` stays 0.
- **Scoreboard:**
  - `busy[iss_addr]` sets when `iss_valid` is high and `iss_addr != 0`.
  - `busy[addr]` clears on a transfer to `addr`.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - `busy[0]` is constant 0.
- **Stall:**
  - For each checked address a (rs1, rs2, rd) with a != 0, compute `hit(a) = busy[a] | (we & wr_addr == a)`.
  - `stall = hit(rs1) | hit(rs2) | busy[rd]`.
  - The `we` term covers the cycle in which the register file has not yet captured the data.
- **Issue rule:** upstream never asserts `iss_valid` while `stall = 1`. Because of this, a second issue to a register that is already busy cannot occur.

## Timing
- **Reset values:** `we = 0`, `wr_addr = 0`, `wr_data = 0`, `busy = 0`, `prio = 0`. `alu_ready` and `lsu_ready` are forced to 0 while `rst_n = 0`.
- **Reset mid-operation:** a pending loser and any unwritten data are discarded. Upstream reissues after reset.
- **Write latency:** transfer at edge N → `we` high during cycle N+1 → register file updated at edge N+1. A reader sees the new value from cycle N+2.
- **Throughput:** one write per cycle. With both requesters continuously valid, grants alternate ALU, LSU, ALU, and so on.
- **Stall path:** combinational from the `chk_*` inputs and current state; no added latency.
- **Simultaneous issue and transfer:** an issue and a transfer to different registers in the same cycle both take effect.

## Structure
- Shared package `regs_pkg`: XLEN, REG_AW, NREG, requester indices REQ_ALU = 0 and REQ_LSU = 1.
- Sub-module `regs_scoreboard`:
  - Inputs: set port, clear port, three check addresses.
  - Outputs: busy vector and stall.
  - The stall's `we` term comes from the write stage.
- Arbiter and write-stage registers live in the top module.

## Test plan
- **Reset:** hold `rst_n = 0` for 2 cycles with both valids high → both readies 0, `we = 0`, `busy = 0`. After release, first grant goes to ALU.
- **Contention:** both valid for 4 cycles (ALU x5 = 0x11, LSU x6 = 0x22) → grants ALU, LSU, ALU, LSU. `we` pulses each cycle, one cycle after each grant, with the matching addr and data.
- **x0 write:** LSU writes x0 with data 0xDEAD → `lsu_ready = 1`, next cycle `we = 0`, `busy` unchanged.
- **Hazard lifetime:** issue x7; with `chk_rs1 = 7`, `stall = 1` until the ALU writes x7. Stall is still 1 in the `we` cycle and drops to 0 the cycle after.
- **Set-wins collision:** issue x9 in the same cycle a transfer to x9 occurs → `busy[9]` remains 1.
- **WAW:** `busy[3] = 1`, `chk_rd = 3` → `stall = 1`. `chk_rd = 0` → no stall contribution.
